// File: rtl/ps2_key_controller_pkg.sv
// Shared definitions for the PS/2 key controller: decoder states,
// protocol byte constants and the 10-bit key event record.
package ps2_key_controller_pkg;

  typedef enum logic [1:0] {
    WAIT_CODE = 2'd0,
    AFTER_E0  = 2'd1,
    AFTER_F0  = 2'd2
  } dec_state_t;

  localparam logic [7:0] BYTE_E0 = 8'hE0;  // extended-key prefix
  localparam logic [7:0] BYTE_F0 = 8'hF0;  // break (release) prefix
  localparam logic [7:0] BYTE_FA = 8'hFA;  // acknowledge
  localparam logic [7:0] BYTE_AA = 8'hAA;  // self-test passed
  localparam logic [7:0] BYTE_EE = 8'hEE;  // echo response
  localparam logic [7:0] BYTE_E1 = 8'hE1;  // pause-key prefix, not decoded
  localparam logic [7:0] BYTE_00 = 8'h00;  // keyboard error / buffer overrun
  localparam logic [7:0] BYTE_FF = 8'hFF;  // keyboard error / buffer overrun

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_event_t;

  // Bytes the keyboard sends to report an internal error.
  function automatic logic is_error_byte(input logic [7:0] b);
    return (b == BYTE_00) || (b == BYTE_FF);
  endfunction

  // Status/response bytes that never form part of a key event.
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == BYTE_FA) || (b == BYTE_AA) || (b == BYTE_EE) || (b == BYTE_E1);
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Small first-word-fall-through FIFO of key events. The head entry is
// visible on dout whenever empty is low; a push to a full FIFO is only
// accepted when a pop frees the head slot in the same cycle.
module ps2_key_fifo
  import ps2_key_controller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  key_event_t                 din,
  output key_event_t                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  key_event_t          mem_reg [DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic                do_push;
  logic                do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_reg[rd_ptr_reg];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 scan-code set 2 decoder: folds E0/F0 prefixes into single key
// events, flags keyboard errors and stalled sequences, and buffers the
// events for a ready/valid consumer.
module ps2_key_controller
  import ps2_key_controller_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       overflow_tick,
  output logic       error_tick
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] RX_EN_LIMIT  = CW'(FIFO_DEPTH - 1);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  dec_state_t     state_reg, state_next;
  logic           ext_reg, ext_next;
  logic           brk_reg, brk_next;
  logic [31:0]    idle_cnt_reg, idle_cnt_next;
  logic           err_reg, err_next;
  logic           ovf_reg;
  logic           rx_en_reg;

  logic           push;
  key_event_t     push_ev;
  logic           pop;
  key_event_t     head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  // Decoder next-state: byte handling first, then the mid-sequence timeout.
  always_comb begin
    state_next    = state_reg;
    ext_next      = ext_reg;
    brk_next      = brk_reg;
    err_next      = 1'b0;
    push          = 1'b0;
    push_ev       = '0;
    idle_cnt_next = (state_reg == WAIT_CODE) ? '0 : idle_cnt_reg + 32'd1;
    if (rx_done_tick) begin
      idle_cnt_next = '0;
      case (state_reg)
        WAIT_CODE: begin
          if (is_error_byte(rx_data)) begin
            err_next = 1'b1;
          end else if (rx_data == BYTE_E0) begin
            ext_next   = 1'b1;
            state_next = AFTER_E0;
          end else if (rx_data == BYTE_F0) begin
            brk_next   = 1'b1;
            state_next = AFTER_F0;
          end else if (!is_status_byte(rx_data)) begin
            push         = 1'b1;
            push_ev.code = rx_data;
          end
        end
        AFTER_E0: begin
          if (is_error_byte(rx_data)) begin
            err_next   = 1'b1;
            ext_next   = 1'b0;
            brk_next   = 1'b0;
            state_next = WAIT_CODE;
          end else if (rx_data == BYTE_F0) begin
            brk_next   = 1'b1;
            state_next = AFTER_F0;
          end else begin
            push         = 1'b1;
            push_ev.code = rx_data;
            push_ev.ext  = 1'b1;
            ext_next     = 1'b0;
            brk_next     = 1'b0;
            state_next   = WAIT_CODE;
          end
        end
        AFTER_F0: begin
          if (is_error_byte(rx_data)) begin
            err_next = 1'b1;
          end else begin
            push         = 1'b1;
            push_ev.code = rx_data;
            push_ev.ext  = ext_reg;
            push_ev.brk  = 1'b1;
          end
          ext_next   = 1'b0;
          brk_next   = 1'b0;
          state_next = WAIT_CODE;
        end
        default: begin
          ext_next   = 1'b0;
          brk_next   = 1'b0;
          state_next = WAIT_CODE;
        end
      endcase
    end else if ((state_reg != WAIT_CODE) && (idle_cnt_reg == TIMEOUT_LAST)) begin
      // The keyboard stalled mid-sequence: abandon the partial code.
      err_next      = 1'b1;
      ext_next      = 1'b0;
      brk_next      = 1'b0;
      idle_cnt_next = '0;
      state_next    = WAIT_CODE;
    end
  end

  // Decoder state, idle counter, status pulses and receive throttle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= WAIT_CODE;
      ext_reg      <= 1'b0;
      brk_reg      <= 1'b0;
      idle_cnt_reg <= '0;
      err_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      rx_en_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ext_reg      <= ext_next;
      brk_reg      <= brk_next;
      idle_cnt_reg <= idle_cnt_next;
      err_reg      <= err_next;
      ovf_reg      <= push && fifo_full && !pop;
      // Throttle one entry early so a frame already in flight still fits.
      rx_en_reg    <= (fifo_count < RX_EN_LIMIT);
    end
  end

  assign pop = key_ready && !fifo_empty;

  ps2_key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_ev),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head fields read as zero while nothing is buffered (including after reset).
  assign key_valid     = !fifo_empty;
  assign key_code      = fifo_empty ? 8'h00 : head.code;
  assign key_ext       = !fifo_empty && head.ext;
  assign key_break     = !fifo_empty && head.brk;
  assign overflow_tick = ovf_reg;
  assign error_tick    = err_reg;
  assign rx_en         = rx_en_reg;

endmodule

// File: doc/ps2_key_controller.md
PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, number of key-event entries (power of two, at least 2); TIMEOUT_CYCLES, default 2_000_000, maximum clk cycles allowed between bytes of one multi-byte sequence.
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- rx_done_tick  in  1  one-cycle pulse from the PS/2 receiver; a byte is valid
- rx_data  in  8  received byte, valid while rx_done_tick=1
- rx_en  out  1  receive enable to the PS/2 receiver
- key_valid  out  1  FIFO head holds an event
- key_ready  in  1  consumer accepts the head event
- key_code  out  8  head scan code
- key_ext  out  1  head event had an E0 prefix
- key_break  out  1  head event is a release (had an F0 prefix)
- overflow_tick  out  1  one-cycle pulse: event dropped because the FIFO was full
- error_tick  out  1  one-cycle pulse: error byte or sequence timeout
REQ-003 The clock and reset SHALL be one clock, clk, and one reset, reset; reset is asynchronous and active-high.

Function
REQ-004 The decoder FSM SHALL have three states: WAIT_CODE, AFTER_E0 and AFTER_F0. Flags ext_reg and brk_reg SHALL record the prefixes seen.
REQ-005 WAIT_CODE transitions SHALL be:
- byte E0: set ext_reg, go to AFTER_E0.
- byte F0: set brk_reg, go to AFTER_F0.
- byte 00 or FF: pulse error_tick, stay.
- byte FA, AA, EE or E1: discard, stay.
- any other byte: push {byte, ext_reg=0, brk_reg=0}.
REQ-006 AFTER_E0 transitions SHALL be:
- byte F0: set brk_reg, go to AFTER_F0.
- byte 00 or FF: pulse error_tick, clear flags, go to WAIT_CODE.
- any other byte: push {byte, ext=1, break=0}, clear flags, go to WAIT_CODE.
REQ-007 AFTER_F0 transitions SHALL be:
- byte 00 or FF: pulse error_tick, clear flags, go to WAIT_CODE.
- any other byte: push {byte, ext_reg, break=1}, clear flags, go to WAIT_CODE.
REQ-008 A 32-bit idle counter SHALL clear on each rx_done_tick and in WAIT_CODE. Otherwise it SHALL increment. When it reaches TIMEOUT_CYCLES, the block SHALL clear the flags, go to WAIT_CODE and pulse error_tick once.
REQ-009 A push SHALL make key_valid=1 on the cycle after rx_done_tick when the FIFO was empty, giving 1-cycle latency.
REQ-010 A pop SHALL occur when key_valid and key_ready are both 1. The head fields SHALL update on the next cycle.
REQ-011 A push to a full FIFO with no pop in the same cycle SHALL drop the event and pulse overflow_tick. A push and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-012 A push and a pop in the same cycle on a FIFO holding one entry SHALL leave key_valid=1 with the new entry at the head.
REQ-013 Pointers SHALL wrap modulo FIFO_DEPTH. The count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-014 rx_en SHALL be registered and equal 1 when count < FIFO_DEPTH-1, otherwise 0. This throttles new frames before the FIFO becomes full.
REQ-015 rx_done_tick SHALL be processed even when rx_en=0, because a frame in flight completes.

Reset
REQ-016 Reset SHALL force:
- FSM to WAIT_CODE; ext_reg, brk_reg, idle counter, pointers and count to 0.
- key_valid=0, key_code=00, key_ext=0, key_break=0, overflow_tick=0, error_tick=0, rx_en=0.
REQ-017 rx_en SHALL go to 1 on the first clk edge after reset is released.
REQ-018 Reset asserted in the middle of a sequence SHALL discard the partial sequence and all buffered events.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, the constants E0, F0, FA, AA, EE, E1, 00, FF, and the 10-bit event record layout {code, ext, break}.
REQ-020 The FIFO SHALL be the sub-module ps2_key_fifo, with push/pop/full/empty/count ports and the same clk/reset.

Verification
REQ-021 Bytes 1C; key_ready=1 -> one event {1C,0,0}, key_valid high exactly 1 cycle.
REQ-022 Bytes E0,F0,74 -> one event {74,ext=1,break=1}; no event emitted for either prefix.
REQ-023 Byte E0, then no byte for TIMEOUT_CYCLES (bench parameter 100), then byte 1C -> one error_tick, then {1C,0,0}.
REQ-024 key_ready=0 and 5 codes with FIFO_DEPTH=4 -> rx_en=0 after the 3rd event, overflow_tick on the 5th, events 1-4 popped in order.
REQ-025 Bytes FF, then FA, then 1C -> error_tick once, FA silently dropped, only {1C,0,0} emitted.
REQ-026 Reset asserted after F0 is received, then byte 1C -> event {1C,0,0}, not a break event.
